// File: rtl/cb_dma_pkg.sv
// Shared state encoding, AXI response code and burst sizing helper for the CB DMA read engine.
package cb_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_AR,
    ST_R,
    ST_DONE,
    ST_ERR
  } dma_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Smallest of remaining beats, the burst cap and the page-boundary limit.
  function automatic logic [8:0] burst_len(input logic [31:0] beats_left,
                                           input logic [8:0]  max_burst,
                                           input logic [31:0] bound_words);
    logic [8:0] b;
    b = (beats_left < {23'd0, max_burst}) ? beats_left[8:0] : max_burst;
    if (bound_words < {23'd0, b}) b = bound_words[8:0];
    return b;
  endfunction

endpackage

// File: rtl/cb_dma_rd_engine.sv
// DDR->SRAM fetch engine: request to first AR in 2 cycles, one burst outstanding, AR held until arready.
// Define CB_DMA_4K_SPLIT_EN to keep every burst inside one 4 KiB page.
module cb_dma_rd_engine
  import cb_dma_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int SRAM_AW   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dma_start,
  input  logic [31:0]        dma_addr,
  input  logic [31:0]        dma_len,
  input  logic               dma_dir,
  output logic               dma_done,
  output logic               dma_error,
  output logic [31:0]        m_araddr,
  output logic [7:0]         m_arlen,
  output logic               m_arvalid,
  input  logic               m_arready,
  input  logic [31:0]        m_rdata,
  input  logic [1:0]         m_rresp,
  input  logic               m_rlast,
  input  logic               m_rvalid,
  output logic               m_rready,
  output logic               sram_wen,
  output logic [SRAM_AW-1:0] sram_waddr,
  output logic [31:0]        sram_wdata
);

  dma_state_e         state_q;
  logic [31:0]        addr_q, len_q, beats_q, araddr_q;
  logic               dir_q, err_q, arvalid_q, rready_q, done_q, error_q;
  logic [8:0]         burst_q, bcnt_q;
  logic [7:0]         arlen_q;
  logic [SRAM_AW-1:0] waddr_q;

  logic [31:0] addr_d, beats_d, bound_d;
  logic [8:0]  burst_d, bcnt_d;
  logic        beat, beat_err, req_bad;

  // Next burst origin: the latched request in CHECK, otherwise just past the current burst.
  always_comb begin
    if (state_q == ST_CHECK) begin
      addr_d  = addr_q;
      beats_d = len_q >> 2;
    end else begin
      addr_d  = addr_q + {21'd0, burst_q, 2'b00};
      beats_d = beats_q - {23'd0, burst_q};
    end
`ifdef CB_DMA_4K_SPLIT_EN
    bound_d = (32'd4096 - {20'd0, addr_d[11:0]}) >> 2;
`else
    bound_d = '1;
`endif
    burst_d = burst_len(beats_d, 9'(MAX_BURST), bound_d);
  end

  assign beat     = m_rvalid & rready_q;
  assign bcnt_d   = bcnt_q + 9'd1;
  // rlast must land exactly on the requested beat count.
  assign beat_err = (m_rresp != AXI_RESP_OKAY) | (m_rlast != (bcnt_d == burst_q));
  assign req_bad  = dir_q | (addr_q[1:0] != 2'b00) | (len_q[1:0] != 2'b00) |
                    ((len_q >> 2) > (32'd1 << SRAM_AW));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      dir_q     <= 1'b0;
      beats_q   <= '0;
      burst_q   <= '0;
      bcnt_q    <= '0;
      err_q     <= 1'b0;
      waddr_q   <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (dma_start) begin
          addr_q  <= dma_addr;
          len_q   <= dma_len;
          dir_q   <= dma_dir;
          err_q   <= 1'b0;
          waddr_q <= '0;
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (req_bad) begin
            error_q <= 1'b1;
            state_q <= ST_ERR;
          end else if (len_q == 32'd0) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            beats_q   <= beats_d;
            burst_q   <= burst_d;
            araddr_q  <= addr_d;
            arlen_q   <= 8'(burst_d - 9'd1);
            arvalid_q <= 1'b1;
            state_q   <= ST_AR;
          end
        end
        ST_AR: if (m_arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          bcnt_q    <= '0;
          state_q   <= ST_R;
        end
        ST_R: if (beat) begin
          waddr_q <= waddr_q + SRAM_AW'(1);
          bcnt_q  <= bcnt_d;
          if (beat_err) err_q <= 1'b1;
          if (m_rlast) begin
            rready_q <= 1'b0;
            addr_q   <= addr_d;
            beats_q  <= beats_d;
            if (err_q | beat_err) begin
              error_q <= 1'b1;
              state_q <= ST_ERR;
            end else if (beats_d == 32'd0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              burst_q   <= burst_d;
              araddr_q  <= addr_d;
              arlen_q   <= 8'(burst_d - 9'd1);
              arvalid_q <= 1'b1;
              state_q   <= ST_AR;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dma_done   = done_q;
  assign dma_error  = error_q;
  assign m_araddr   = araddr_q;
  assign m_arlen    = arlen_q;
  assign m_arvalid  = arvalid_q;
  assign m_rready   = rready_q;
  assign sram_wen   = beat;
  assign sram_waddr = waddr_q;
  assign sram_wdata = beat ? m_rdata : 32'd0;

endmodule

// File: tb/tb_cb_dma_rd_engine.sv
// Bench for cb_dma_rd_engine: directed vector table, reset/ignore sequences, random requests vs a burst model.
`timescale 1ns/1ps
module tb_cb_dma_rd_engine;
  localparam int MAXB = 16;
  localparam int AW   = 10;
`ifdef CB_DMA_4K_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          dma_start = 1'b0, dma_dir = 1'b0;
  logic [31:0]   dma_addr = '0, dma_len = '0;
  logic          dma_done, dma_error, m_arvalid, m_rready, sram_wen;
  logic [31:0]   m_araddr, sram_wdata;
  logic [7:0]    m_arlen;
  logic          m_arready = 1'b0, m_rlast = 1'b0, m_rvalid = 1'b0;
  logic [31:0]   m_rdata = '0;
  logic [1:0]    m_rresp = '0;
  logic [AW-1:0] sram_waddr;

  always #5 clk = ~clk;

  cb_dma_rd_engine #(.MAX_BURST(MAXB), .SRAM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .dma_start(dma_start), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_dir(dma_dir), .dma_done(dma_done), .dma_error(dma_error), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .sram_wen(sram_wen), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata));

  int total = 0, bad = 0;
  bit timed_out = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ddr(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // observation logs, filled by the monitor
  int cyc = 0, start_cyc = -1, first_ar_cyc = -1, end_cyc = -1;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, wr_cnt = 0, arv_cycles = 0;
  logic [31:0] ar_a_log[$];
  logic [7:0]  ar_l_log[$];
  logic [31:0] sram_img [0:(1<<AW)-1];
  bit          ar_hold = 0;
  logic [31:0] hold_a = '0;
  logic [7:0]  hold_l = '0;

  // slave configuration and state
  int stall = 0, err_burst = 0, err_beat = 0, rl_delta = 0;
  bit s_act = 0, hs_ar = 0, hs_r = 0;
  logic [31:0] s_addr = '0, smp_a = '0;
  logic [7:0]  smp_l = '0;
  int s_n = 0, s_i = 0, s_bidx = 0;

  // model expectations
  logic [31:0] exp_a[$];
  logic [7:0]  exp_l[$];
  int exp_nwr = 0;
  bit exp_ok = 0;

  // Monitor at negedge, AXI slave reacts just after the following posedge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (dma_start && start_cyc < 0) start_cyc = cyc;
      if (m_arvalid) begin
        arv_cycles++;
        if (first_ar_cyc < 0) first_ar_cyc = cyc;
      end
      if ((dma_done || dma_error) && end_cyc < 0) end_cyc = cyc;
      if (dma_done) done_cnt++;
      if (dma_error) err_cnt++;
      if (dma_done && dma_error) both_cnt++;
      if (sram_wen) begin
        sram_img[sram_waddr] = sram_wdata;
        wr_cnt++;
      end
      if (ar_hold && m_arvalid) begin
        chk("ar_addr_stable", m_araddr, hold_a);
        chk("ar_len_stable", {24'd0, m_arlen}, {24'd0, hold_l});
      end
      ar_hold = m_arvalid && !m_arready;
      hold_a  = m_araddr;
      hold_l  = m_arlen;
      hs_ar   = m_arvalid && m_arready;
      hs_r    = m_rvalid && m_rready;
      if (hs_ar) begin
        ar_a_log.push_back(m_araddr);
        ar_l_log.push_back(m_arlen);
        smp_a = m_araddr;
        smp_l = m_arlen;
      end
      tick();
      if (!rst_n) begin
        s_act = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rresp = 0; m_rdata = 0; ar_hold = 0;
      end else begin
        if (hs_r) begin
          s_i++;
          if (s_i >= s_n) s_act = 0;
        end
        if (hs_ar) begin
          s_act = 1; s_addr = smp_a; s_i = 0; s_bidx++;
          s_n = int'(smp_l) + 1 + ((s_bidx == 1) ? rl_delta : 0);
        end
        m_arready = !s_act && ($urandom_range(0, 99) >= stall);
        if (!(m_rvalid && !hs_r)) m_rvalid = s_act && ($urandom_range(0, 99) >= stall);
        if (s_act) begin
          m_rdata = ddr(s_addr + 32'(4 * s_i));
          m_rlast = (s_i == s_n - 1);
          m_rresp = (s_bidx == err_burst && s_i == err_beat) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  task automatic clear_logs();
    start_cyc = -1; first_ar_cyc = -1; end_cyc = -1;
    done_cnt = 0; err_cnt = 0; both_cnt = 0; wr_cnt = 0; arv_cycles = 0;
    ar_a_log.delete(); ar_l_log.delete();
    for (int i = 0; i < (1 << AW); i++) sram_img[i] = 32'hDEAD_BEEF;
    s_bidx = 0;
  endtask

  task automatic run_req(input logic [31:0] a, input logic [31:0] l, input logic d, input int glitch);
    if (timed_out) return;
    clear_logs();
    dma_addr = a; dma_len = l; dma_dir = d; dma_start = 1;
    tick();
    dma_start = 0; dma_addr = 32'hFFFF_FFF0; dma_len = 32'd4; dma_dir = 0;
    for (int i = 1; i < 4000 && (done_cnt + err_cnt) == 0; i++) begin
      if (i == glitch) dma_start = 1;
      tick();
      dma_start = 0;
    end
    repeat (4) tick();
    if ((done_cnt + err_cnt) == 0) timed_out = 1;
  endtask

  // Reference: request rules and burst splitting from plain arithmetic.
  task automatic model(input logic [31:0] a, input logic [31:0] l, input logic d, input int eb, input int dl);
    longint left, addr, b, got, page;
    int k;
    bit fail;
    exp_a.delete(); exp_l.delete(); exp_nwr = 0; exp_ok = 0;
    if (d || a[1:0] != 2'b00 || l[1:0] != 2'b00 || (l / 4) > (1 << AW)) return;
    left = longint'(l / 4); addr = longint'(a); k = 0; fail = 0;
    while (left > 0 && !fail) begin
      b = (left < MAXB) ? left : MAXB;
      page = (4096 - (addr % 4096)) / 4;
      if (SPLIT && page < b) b = page;
      exp_a.push_back(addr[31:0]);
      exp_l.push_back(8'(b - 1));
      k++;
      got = b + ((k == 1) ? dl : 0);
      exp_nwr += int'(got);
      if (k == eb || (k == 1 && dl != 0)) fail = 1;
      addr += 4 * b;
      left -= b;
    end
    exp_ok = !fail;
  endtask

  task automatic check_common(input string tag, input logic [31:0] a, input int e_done, input int e_err,
                              input int e_nar, input int e_nwr);
    int mism;
    chk({tag, ".done"}, done_cnt, e_done);
    chk({tag, ".error"}, err_cnt, e_err);
    chk({tag, ".both"}, both_cnt, 0);
    chk({tag, ".n_ar"}, ar_a_log.size(), e_nar);
    chk({tag, ".arvalid_seen"}, arv_cycles > 0, e_nar > 0);
    if (e_nar > 0) chk({tag, ".ar_latency"}, first_ar_cyc - start_cyc, 2);
    else           chk({tag, ".end_latency"}, end_cyc - start_cyc, 2);
    chk({tag, ".n_wr"}, wr_cnt, e_nwr);
    mism = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      if (i < e_nwr) begin
        if (sram_img[i] !== ddr(a + 32'(4 * i))) mism++;
      end else if (sram_img[i] !== 32'hDEAD_BEEF) mism++;
    end
    chk({tag, ".sram"}, mism, 0);
  endtask

  typedef struct {
    logic [31:0] a, l;
    logic        d;
    int          eb, ebt, dl, st, gl;
    int          e_done, e_err, e_nar;
    logic [31:0] ar0a;
    logic [7:0]  ar0l;
    logic [31:0] ar1a;
    int          e_nwr;
  } vec_t;

  localparam int NV = 14;
  vec_t tv [NV];

  initial begin
    string tag;
    logic [31:0] ra, rl;
    logic rd;
    int mism;

    tv[0]  = '{32'h2000_0000, 32'd128,  1'b0, 0, 0, 0,  0,  0, 1, 0, 2,  32'h2000_0000, 8'd15, 32'h2000_0040, 32};
    tv[1]  = '{32'h2000_0100, 32'd20,   1'b0, 0, 0, 0,  10, 0, 1, 0, 1,  32'h2000_0100, 8'd4,  32'h0, 5};
    tv[2]  = '{32'h2000_0000, 32'd0,    1'b0, 0, 0, 0,  0,  0, 1, 0, 0,  32'h0, 8'd0, 32'h0, 0};
    tv[3]  = '{32'h2000_0000, 32'd64,   1'b1, 0, 0, 0,  0,  0, 0, 1, 0,  32'h0, 8'd0, 32'h0, 0};
    tv[4]  = '{32'h1000_0002, 32'd64,   1'b0, 0, 0, 0,  0,  0, 0, 1, 0,  32'h0, 8'd0, 32'h0, 0};
    tv[5]  = '{32'h2000_0000, 32'd6,    1'b0, 0, 0, 0,  0,  0, 0, 1, 0,  32'h0, 8'd0, 32'h0, 0};
    tv[6]  = '{32'h2000_0000, 32'd4100, 1'b0, 0, 0, 0,  0,  0, 0, 1, 0,  32'h0, 8'd0, 32'h0, 0};
    tv[7]  = '{32'h3000_0000, 32'd4096, 1'b0, 0, 0, 0,  0,  0, 1, 0, 64, 32'h3000_0000, 8'd15, 32'h3000_0040, 1024};
    tv[8]  = '{32'h2000_0000, 32'd128,  1'b0, 1, 2, 0,  20, 0, 0, 1, 1,  32'h2000_0000, 8'd15, 32'h0, 16};
    tv[9]  = '{32'h2000_0000, 32'd64,   1'b0, 0, 0, -5, 0,  0, 0, 1, 1,  32'h2000_0000, 8'd15, 32'h0, 11};
    tv[10] = '{32'h2000_0000, 32'd64,   1'b0, 0, 0, 2,  0,  0, 0, 1, 1,  32'h2000_0000, 8'd15, 32'h0, 18};
    tv[11] = '{32'h2000_0000, 32'd64,   1'b0, 0, 0, 0,  40, 6, 1, 0, 1,  32'h2000_0000, 8'd15, 32'h0, 16};
`ifdef CB_DMA_4K_SPLIT_EN
    tv[12] = '{32'h2000_0FF0, 32'd64,   1'b0, 0, 0, 0,  0,  0, 1, 0, 2,  32'h2000_0FF0, 8'd3,  32'h2000_1000, 16};
`else
    tv[12] = '{32'h2000_0FF0, 32'd64,   1'b0, 0, 0, 0,  0,  0, 1, 0, 1,  32'h2000_0FF0, 8'd15, 32'h0, 16};
`endif
    tv[13] = '{32'h2000_4000, 32'd200,  1'b0, 0, 0, 0,  50, 0, 1, 0, 4,  32'h2000_4000, 8'd15, 32'h2000_4040, 50};

    rst_n = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst.arvalid", m_arvalid, 0);
    chk("rst.rready", m_rready, 0);
    chk("rst.done", dma_done, 0);
    chk("rst.error", dma_error, 0);
    chk("rst.wen", sram_wen, 0);
    chk("rst.araddr", m_araddr, 0);
    chk("rst.arlen", m_arlen, 0);
    chk("rst.waddr", sram_waddr, 0);
    chk("rst.wdata", sram_wdata, 0);
    tick();
    rst_n = 1;
    tick();

    for (int i = 0; i < NV && !timed_out; i++) begin
      stall = tv[i].st; err_burst = tv[i].eb; err_beat = tv[i].ebt; rl_delta = tv[i].dl;
      run_req(tv[i].a, tv[i].l, tv[i].d, tv[i].gl);
      tag = $sformatf("vec%0d", i);
      check_common(tag, tv[i].a, tv[i].e_done, tv[i].e_err, tv[i].e_nar, tv[i].e_nwr);
      if (tv[i].e_nar >= 1 && ar_a_log.size() >= 1) begin
        chk({tag, ".ar0_addr"}, ar_a_log[0], tv[i].ar0a);
        chk({tag, ".ar0_len"}, {24'd0, ar_l_log[0]}, {24'd0, tv[i].ar0l});
      end
      if (tv[i].e_nar >= 2 && ar_a_log.size() >= 2)
        chk({tag, ".ar1_addr"}, ar_a_log[1], tv[i].ar1a);
    end
    err_burst = 0; err_beat = 0; rl_delta = 0;

    // reset in the middle of a burst
    if (!timed_out) begin
      clear_logs();
      stall = 20;
      dma_addr = 32'h2000_0000; dma_len = 32'd128; dma_dir = 0; dma_start = 1;
      tick();
      dma_start = 0;
      for (int i = 0; i < 500 && wr_cnt < 5; i++) tick();
      chk("rstmid.progress", wr_cnt >= 5, 1);
      rst_n = 0;
      @(posedge clk);
      @(negedge clk);
      chk("rstmid.arvalid", m_arvalid, 0);
      chk("rstmid.rready", m_rready, 0);
      chk("rstmid.wen", sram_wen, 0);
      chk("rstmid.waddr", sram_waddr, 0);
      chk("rstmid.wdata", sram_wdata, 0);
      chk("rstmid.araddr", m_araddr, 0);
      chk("rstmid.pulses", dma_done | dma_error, 0);
      repeat (2) tick();
      rst_n = 1;
      repeat (5) tick();
      chk("rstmid.no_pulse", done_cnt + err_cnt, 0);
      model(32'h2000_8000, 32'd64, 1'b0, 0, 0);
      run_req(32'h2000_8000, 32'd64, 1'b0, 0);
      check_common("rstmid.after", 32'h2000_8000, 1, 0, exp_a.size(), exp_nwr);
    end

    for (int n = 0; n < 40 && !timed_out; n++) begin
      ra = 32'h2000_0000 + ($urandom_range(0, 4095) << 2);
      rl = $urandom_range(0, 96) << 2;
      rd = 1'b0;
      case ($urandom_range(0, 9))
        0: rd = 1'b1;
        1: ra[1:0] = 2'($urandom_range(1, 3));
        2: rl = rl + 32'($urandom_range(1, 3));
        default: ;
      endcase
      err_burst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      err_beat = 0; rl_delta = 0;
      stall = $urandom_range(0, 60);
      model(ra, rl, rd, err_burst, 0);
      run_req(ra, rl, rd, 0);
      tag = $sformatf("rnd%0d", n);
      check_common(tag, ra, exp_ok ? 1 : 0, exp_ok ? 0 : 1, exp_a.size(), exp_nwr);
      mism = (ar_a_log.size() == exp_a.size()) ? 0 : 1;
      for (int i = 0; i < exp_a.size() && i < ar_a_log.size(); i++)
        if (ar_a_log[i] !== exp_a[i] || ar_l_log[i] !== exp_l[i]) mism++;
      chk({tag, ".ar_seq"}, mism, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
